// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter and sequencer sharing one external RAM port between
// the filter core (requester 0) and the load/readback engine (requester 1).
module ram_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              mem_RE_RAM,
    output logic              mem_WE_RAM,
    output logic [ADDR_W-1:0] Data_Dir_RAM,
    output logic [DATA_W-1:0] Data_RAM,
    input  logic [DATA_W-1:0] Data_in_RAM,
    output logic              busy,
    output logic              owner
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          cnt_q, cnt_d;
    logic                owner_q, owner_d;
    logic                tx_we_q, tx_we_d;
    logic                re_q, re_d;
    logic                wes_q, wes_d;
    logic [ADDR_W-1:0]   dir_q, dir_d;
    logic [DATA_W-1:0]   dout_q, dout_d;
    logic                ack0_q, ack0_d;
    logic                ack1_q, ack1_d;
    logic [DATA_W-1:0]   rdata0_q, rdata0_d;
    logic [DATA_W-1:0]   rdata1_q, rdata1_d;
    logic                busy_q, busy_d;
    logic                win;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        owner_d  = owner_q;
        tx_we_d  = tx_we_q;
        re_d     = 1'b0;
        wes_d    = 1'b0;
        dir_d    = dir_q;
        dout_d   = dout_q;
        ack0_d   = 1'b0;
        ack1_d   = 1'b0;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        win      = (req0 && req1) ? ~owner_q : req1;

        unique case (state_q)
            S_IDLE: begin
                // Strobes are registered, so they are launched on the grant edge
                // and are therefore high throughout the ISSUE cycle.
                if (req0 || req1) begin
                    owner_d = win;
                    tx_we_d = win ? we1 : we0;
                    dir_d   = win ? addr1 : addr0;
                    if (win ? we1 : we0) begin
                        dout_d = win ? wdata1 : wdata0;
                        wes_d  = 1'b1;
                    end else begin
                        re_d = 1'b1;
                    end
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (tx_we_q) begin
                    state_d = S_DONE;
                    ack0_d  = ~owner_q;
                    ack1_d  = owner_q;
                end else begin
                    state_d = S_WAIT;
                    cnt_d   = 2'(RD_LAT - 1);
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    if (owner_q) begin
                        rdata1_d = Data_in_RAM;
                    end else begin
                        rdata0_d = Data_in_RAM;
                    end
                    state_d = S_DONE;
                    ack0_d  = ~owner_q;
                    ack1_d  = owner_q;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            owner_q  <= 1'b1;
            tx_we_q  <= 1'b0;
            re_q     <= 1'b0;
            wes_q    <= 1'b0;
            dir_q    <= '0;
            dout_q   <= '0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            owner_q  <= owner_d;
            tx_we_q  <= tx_we_d;
            re_q     <= re_d;
            wes_q    <= wes_d;
            dir_q    <= dir_d;
            dout_q   <= dout_d;
            ack0_q   <= ack0_d;
            ack1_q   <= ack1_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
            busy_q   <= busy_d;
        end
    end

    assign ack0         = ack0_q;
    assign ack1         = ack1_q;
    assign rdata0       = rdata0_q;
    assign rdata1       = rdata1_q;
    assign mem_RE_RAM   = re_q;
    assign mem_WE_RAM   = wes_q;
    assign Data_Dir_RAM = dir_q;
    assign Data_RAM     = dout_q;
    assign busy         = busy_q;
    assign owner        = owner_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: two instances (read latency 1 and 3) share the
// requester inputs; a transaction-age model predicts every output each cycle.
module tb_ram_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0, req1, we0, we1;
    logic [31:0] addr0, addr1;
    logic [7:0]  wdata0, wdata1;

    logic [1:0]  ack0_o, ack1_o, re_o, wes_o, busy_o, owner_o;
    logic [7:0]  rd0_o [2];
    logic [7:0]  rd1_o [2];
    logic [31:0] dir_o [2];
    logic [7:0]  dram_o [2];
    logic [7:0]  din [2];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ram_port_arbiter #(.ADDR_W(32), .DATA_W(8), .RD_LAT(1)) u_lat1 (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0_o[0]), .ack1(ack1_o[0]), .rdata0(rd0_o[0]), .rdata1(rd1_o[0]),
        .mem_RE_RAM(re_o[0]), .mem_WE_RAM(wes_o[0]), .Data_Dir_RAM(dir_o[0]),
        .Data_RAM(dram_o[0]), .Data_in_RAM(din[0]), .busy(busy_o[0]), .owner(owner_o[0])
    );

    ram_port_arbiter #(.ADDR_W(32), .DATA_W(8), .RD_LAT(3)) u_lat3 (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0_o[1]), .ack1(ack1_o[1]), .rdata0(rd0_o[1]), .rdata1(rd1_o[1]),
        .mem_RE_RAM(re_o[1]), .mem_WE_RAM(wes_o[1]), .Data_Dir_RAM(dir_o[1]),
        .Data_RAM(dram_o[1]), .Data_in_RAM(din[1]), .busy(busy_o[1]), .owner(owner_o[1])
    );

    function automatic int lat(int d);
        return (d == 0) ? 1 : 3;
    endfunction

    function automatic logic [7:0] init_val(logic [7:0] a);
        return (a == 8'h20) ? 8'h3C : (a ^ 8'h96);
    endfunction

    // RAM behavioural model: data appears lat(d) cycles after RE, else junk.
    logic [7:0] ram    [2][256] = '{default: '0};
    logic       ram_wr [2][256] = '{default: '0};
    logic [7:0] pd     [2][4]   = '{default: '0};
    logic       pv     [2][4]   = '{default: '0};

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (wes_o[d]) begin
                ram[d][dir_o[d][7:0]]    <= dram_o[d];
                ram_wr[d][dir_o[d][7:0]] <= 1'b1;
            end
            pv[d][0] <= re_o[d];
            pd[d][0] <= ram_wr[d][dir_o[d][7:0]] ? ram[d][dir_o[d][7:0]] : init_val(dir_o[d][7:0]);
            for (int k = 1; k < 4; k++) begin
                pv[d][k] <= pv[d][k-1];
                pd[d][k] <= pd[d][k-1];
            end
        end
    end

    always_comb begin
        for (int d = 0; d < 2; d++) begin
            din[d] = pv[d][lat(d)-1] ? pd[d][lat(d)-1] : 8'hEE;
        end
    end

    // Reference model: a transaction is tracked by its age m_t (1 = strobe cycle);
    // it lasts 2 cycles for a write and 2+latency for a read, then one idle cycle.
    logic        m_act   [2];
    int          m_t     [2];
    logic        m_who   [2];
    logic        m_we    [2];
    logic [31:0] m_addr  [2];
    logic        m_owner [2];
    logic [31:0] m_dir   [2];
    logic [7:0]  m_dram  [2];
    logic [7:0]  m_rd0   [2];
    logic [7:0]  m_rd1   [2];
    logic [7:0]  rm      [2][256] = '{default: '0};
    logic        rm_wr   [2][256] = '{default: '0};
    logic        g_win   [2];
    logic        g_we    [2];

    function automatic int tlen(int d);
        return m_we[d] ? 2 : 2 + lat(d);
    endfunction

    function automatic logic [7:0] mref(int d, logic [31:0] a);
        return rm_wr[d][a[7:0]] ? rm[d][a[7:0]] : init_val(a[7:0]);
    endfunction

    always_comb begin
        for (int d = 0; d < 2; d++) begin
            g_win[d] = (req0 && req1) ? !m_owner[d] : req1;
            g_we[d]  = g_win[d] ? we1 : we0;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                m_act[d]   <= 1'b0;
                m_t[d]     <= 0;
                m_who[d]   <= 1'b0;
                m_we[d]    <= 1'b0;
                m_addr[d]  <= '0;
                m_owner[d] <= 1'b1;
                m_dir[d]   <= '0;
                m_dram[d]  <= '0;
                m_rd0[d]   <= '0;
                m_rd1[d]   <= '0;
            end else if (m_act[d]) begin
                if (m_t[d] == tlen(d)) begin
                    m_act[d] <= 1'b0;
                end else begin
                    m_t[d] <= m_t[d] + 1;
                    if (!m_we[d] && (m_t[d] + 1 == tlen(d))) begin
                        if (m_who[d]) m_rd1[d] <= mref(d, m_addr[d]);
                        else          m_rd0[d] <= mref(d, m_addr[d]);
                    end
                end
            end else if (req0 || req1) begin
                m_act[d]   <= 1'b1;
                m_t[d]     <= 1;
                m_who[d]   <= g_win[d];
                m_owner[d] <= g_win[d];
                m_we[d]    <= g_we[d];
                m_addr[d]  <= g_win[d] ? addr1 : addr0;
                m_dir[d]   <= g_win[d] ? addr1 : addr0;
                if (g_we[d]) begin
                    m_dram[d] <= g_win[d] ? wdata1 : wdata0;
                    rm[d][(g_win[d] ? addr1[7:0] : addr0[7:0])]    <= g_win[d] ? wdata1 : wdata0;
                    rm_wr[d][(g_win[d] ? addr1[7:0] : addr0[7:0])] <= 1'b1;
                end
            end
        end
    end

    task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s [lat%0d] got %h expected %h at %0t", nm, lat(d), act, exp, $time);
        end
    endtask

    task automatic compare_all();
        for (int d = 0; d < 2; d++) begin
            chk("busy",   d, busy_o[d],  m_act[d]);
            chk("re",     d, re_o[d],    m_act[d] && m_t[d] == 1 && !m_we[d]);
            chk("we",     d, wes_o[d],   m_act[d] && m_t[d] == 1 && m_we[d]);
            chk("ack0",   d, ack0_o[d],  m_act[d] && m_t[d] == tlen(d) && !m_who[d]);
            chk("ack1",   d, ack1_o[d],  m_act[d] && m_t[d] == tlen(d) && m_who[d]);
            chk("owner",  d, owner_o[d], m_owner[d]);
            chk("addr",   d, dir_o[d],   m_dir[d]);
            chk("wdata",  d, dram_o[d],  m_dram[d]);
            chk("rdata0", d, rd0_o[d],   m_rd0[d]);
            chk("rdata1", d, rd1_o[d],   m_rd1[d]);
        end
    endtask

    // Inputs change at the falling edge; the next rising edge samples them and
    // the outputs of the following cycle are checked at its falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        rst_n = 1'b0;
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("lit_rst_owner", 0, owner_o[0], 1'b1);
        chk("lit_rst_busy",  1, busy_o[1],  1'b0);

        // Single write from requester 0
        req0 = 1'b1; we0 = 1'b1; addr0 = 32'h10; wdata0 = 8'hA5;
        step();
        chk("lit_wr_strobe", 0, wes_o[0],  1'b1);
        chk("lit_wr_addr",   0, dir_o[0],  32'h10);
        chk("lit_wr_data",   0, dram_o[0], 8'hA5);
        step();
        chk("lit_wr_ack0",   0, ack0_o[0], 1'b1);
        req0 = 1'b0;
        repeat (2) step();

        // Single read from requester 1
        req1 = 1'b1; we1 = 1'b0; addr1 = 32'h20;
        step();
        chk("lit_rd_re",     0, re_o[0],   1'b1);
        chk("lit_rd_re",     1, re_o[1],   1'b1);
        step();
        step();
        chk("lit_rd_ack1",   0, ack1_o[0], 1'b1);
        chk("lit_rd_data1",  0, rd1_o[0],  8'h3C);
        chk("lit_rd_data0",  0, rd0_o[0],  8'h00);
        req1 = 1'b0;
        step();
        chk("lit_lat3_busy", 1, busy_o[1], 1'b1);
        step();
        chk("lit_lat3_ack1", 1, ack1_o[1], 1'b1);
        chk("lit_lat3_data", 1, rd1_o[1],  8'h3C);
        repeat (2) step();

        // Reset in the middle of a read
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h33;
        step();
        chk("lit_abort_re_before", 1, re_o[1], 1'b1);
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("lit_abort_re",    d, re_o[d],    1'b0);
            chk("lit_abort_busy",  d, busy_o[d],  1'b0);
            chk("lit_abort_owner", d, owner_o[d], 1'b1);
            chk("lit_abort_ack0",  d, ack0_o[d],  1'b0);
        end
        req0 = 1'b0;
        step();
        rst_n = 1'b1;
        repeat (6) step();

        // Both requesting: grants alternate starting with requester 0
        req0 = 1'b1; req1 = 1'b1; we0 = 1'b1; we1 = 1'b1;
        addr0 = 32'h40; addr1 = 32'h41; wdata0 = 8'h11; wdata1 = 8'h22;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("lit_rr_owner", 0, owner_o[0], 32'(i % 2));
            chk("lit_rr_owner", 1, owner_o[1], 32'(i % 2));
            step();
            if (i % 2 == 0) wdata0 = wdata0 + 8'h01;
            else            wdata1 = wdata1 + 8'h01;
            step();
        end
        req0 = 1'b0; req1 = 1'b0;
        repeat (3) step();

        // Early request drop during a write
        req0 = 1'b1; we0 = 1'b1; addr0 = 32'h50; wdata0 = 8'h77;
        step();
        req0 = 1'b0;
        chk("lit_drop_we",   0, wes_o[0],  1'b1);
        step();
        chk("lit_drop_ack0", 0, ack0_o[0], 1'b1);
        step();
        step();
        chk("lit_drop_idle", 0, busy_o[0], 1'b0);
        chk("lit_drop_nowe", 0, wes_o[0],  1'b0);

        // Read back what was written, then a requester-1 read leaves rdata0 alone
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h50;
        step(); step(); step();
        req0 = 1'b0;
        step(); step();
        chk("lit_rb_data0", 0, rd0_o[0], 8'h77);
        chk("lit_rb_data0", 1, rd0_o[1], 8'h77);
        step();
        req1 = 1'b1; we1 = 1'b0; addr1 = 32'h07;
        step(); step(); step();
        req1 = 1'b0;
        repeat (4) step();
        chk("lit_keep_rd0", 1, rd0_o[1], 8'h77);
        chk("lit_rd1_new",  1, rd1_o[1], 8'h07 ^ 8'h96);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Two-requester arbiter and sequencer for the single 8-bit external RAM port of the filter processor. It lets the filter core and the image load/readback engine share `mem_RE_RAM`/`mem_WE_RAM`/`Data_Dir_RAM`/`Data_RAM`/`Data_in_RAM`. It grants one transaction at a time using round-robin priority and drives one-cycle RAM strobes. It returns read data with a single-cycle `ack` to the winning requester.

## Interface
Parameters:
- `ADDR_W`, 32: RAM address width.
- `DATA_W`, 8: RAM data width.
- `RD_LAT`, 1: RAM read latency in cycles, legal range 1..4.

Ports (clock and reset: one clock; reset is asynchronous and active-low):
- `clk` input 1: system clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `req0`, `req1` input 1: transaction request from requester 0 (filter core) and requester 1 (load/readback engine).
- `we0`, `we1` input 1: 1 = write, 0 = read. Valid while the matching `req` is high.
- `addr0`, `addr1` input ADDR_W: transaction address.
- `wdata0`, `wdata1` input DATA_W: write data.
- `ack0`, `ack1` output 1: one-cycle completion pulse.
- `rdata0`, `rdata1` output DATA_W: read data, valid in the `ack` cycle and held afterwards.
- `mem_RE_RAM` output 1: RAM read strobe.
- `mem_WE_RAM` output 1: RAM write strobe.
- `Data_Dir_RAM` output ADDR_W: RAM address.
- `Data_RAM` output DATA_W: RAM write data.
- `Data_in_RAM` input DATA_W: RAM read data.
- `busy` output 1: high in every state except IDLE.
- `owner` output 1: index of the current or most recent grant.

## Operation
- FSM states: IDLE → ISSUE → (read: WAIT ×RD_LAT) → DONE → IDLE.
- **IDLE:** evaluate `req0`/`req1`.
  - Exactly one request high: that requester wins.
  - Both high: the requester ≠ `owner` wins (round-robin).
  - On a win: latch `we`, `addr`, `wdata` of the winner; set `owner`; go to ISSUE.
- **ISSUE** (exactly one cycle):
  - Drive `Data_Dir_RAM` from the latched address.
  - Write: `Data_RAM` = latched data, `mem_WE_RAM`=1.
  - Read: `mem_RE_RAM`=1.
  - Next state: DONE for a write, WAIT for a read.
- **WAIT:** count RD_LAT cycles. Capture `Data_in_RAM` into the winner's `rdata` register on the rising edge ending the last WAIT cycle. Then go to DONE.
- **DONE:** `ack[owner]`=1 for one cycle, then go to IDLE. Requests are not evaluated in DONE.
- The loser's `rdata` is never modified.
- Requester contract:
  - Hold `req`/`we`/`addr`/`wdata` stable until `ack`.
  - Drop `req` in the cycle after `ack` unless issuing a new transaction.
  - If `req` drops early, the latched transaction still completes and `ack` still pulses.
- Between strobes, `Data_Dir_RAM` and `Data_RAM` hold their last driven value. Strobes are never both high.

## Timing
- Reset (async assert) forces:
  - state IDLE;
  - all strobes, `ack0`, `ack1`, `busy` = 0;
  - `Data_Dir_RAM`, `Data_RAM`, `rdata0`, `rdata1` = 0;
  - `owner`=1, so requester 0 wins the first simultaneous contest.
- Reset asserted mid-transaction aborts it: strobes fall immediately and no `ack` is issued. Deassertion is synchronised to `clk` by the integration level.
- All outputs are registered.
- Latency, with C0 = IDLE cycle in which `req` is sampled high:
  - ISSUE = C1.
  - Write `ack` in C2.
  - Read `ack` in C2+RD_LAT.
- Back-to-back requests: the next ISSUE is at earliest 2 cycles after the `ack` cycle. The IDLE cycle follows DONE.
- Sustained throughput: one write per 3 cycles; one read per 3+RD_LAT cycles.
- Both requesters continuously requesting: grants strictly alternate 0,1,0,1…; no starvation.
- A request arriving during `busy` is held off until the next IDLE cycle.

## Test plan
- **Reset values:** assert `rst_n`=0 mid-read → strobes, `ack*`, `busy` drop immediately; `owner`=1; no `ack` after release.
- **Single write, requester 0:** `req0`=1, `we0`=1, `addr0`=0x00000010, `wdata0`=0xA5 → C1: `mem_WE_RAM`=1, `Data_Dir_RAM`=0x10, `Data_RAM`=0xA5; C2: `ack0`=1.
- **Single read, requester 1, RD_LAT=1:** `addr1`=0x20, RAM model returns 0x3C one cycle after RE → C1: `mem_RE_RAM`=1; C3: `ack1`=1, `rdata1`=0x3C; `rdata0` unchanged.
- **Simultaneous requests after reset:** both `req` high → requester 0 served first, then requester 1; with both held high for 6 transactions, `owner` sequence is 0,1,0,1,0,1.
- **RD_LAT=3 read:** `ack` lands in C5; the sampled data is the RAM output at the end of C4.
- **Early `req` drop:** `req0` falls in C1 of a write → the write still strobes once and `ack0` pulses in C2; no second transaction.
